raster_pattern_source: RTL and testbench

Synthetic Bayer-raster stream generator that drives the pixel-stream input side of image_processing_pipeline (iDATA/iDVAL/iX_Cont/iY_Cont) in place of the camera capture path. On a start request it emits one full frame of rows, one pixel per clock, with per-row horizontal blanking. Pixel values follow a selectable pattern: uniform, vertical edge, horizontal edge or ramp. Used for on-board self-test and as a reusable bench stimulus source.

---
 rtl/raster_pkg.sv | 17 +
 rtl/raster_counter.sv | 49 ++++
 rtl/raster_pattern_source.sv | 142 ++++++++++++++
 tb/tb_raster_pattern_source.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// raster_pkg: pattern-mode constants and FSM state encoding
// shared by raster_pattern_source and its counter.
package raster_pkg;

  localparam logic [1:0] MODE_UNIFORM = 2'd0;
  localparam logic [1:0] MODE_VEDGE   = 2'd1;
  localparam logic [1:0] MODE_HEDGE   = 2'd2;
  localparam logic [1:0] MODE_RAMP    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y/blank position counters for one raster frame.
// Ports: clr/x_step/row_step/blk_en controls; x, y, eol/eob/eof flags.
module raster_counter #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        x_step,
  input  logic        row_step,
  input  logic        blk_en,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        eol,
  output logic        eob,
  output logic        eof
);

  logic [15:0] blank;

  assign eol = (x == 16'(H_ACTIVE - 1));
  assign eob = (blank == 16'(H_BLANK - 1));
  assign eof = (y == 16'(V_ACTIVE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      blank <= '0;
    end else if (clr) begin
      x     <= '0;
      y     <= '0;
      blank <= '0;
    end else begin
      if (x_step)
        x <= x + 16'd1;
      else if (row_step)
        x <= '0;
      if (row_step)
        y <= y + 16'd1;
      // blank restarts at zero whenever a blanking run completes
      if (blk_en)
        blank <= eob ? 16'd0 : blank + 16'd1;
    end
  end

endmodule

// File: rtl/raster_pattern_source.sv
// raster_pattern_source: synthetic Bayer-raster frame generator.
// Ports: iCLK/iRST/iSTART, pattern config in; pixel stream, busy/done, frame count out.
module raster_pattern_source
  import raster_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 10,
  parameter int DATA_W   = 12
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic [1:0]        iMODE,
  input  logic [DATA_W-1:0] iVAL_A,
  input  logic [DATA_W-1:0] iVAL_B,
  input  logic [15:0]       iSPLIT_X,
  input  logic [15:0]       iSPLIT_Y,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [15:0]       oX_Cont,
  output logic [15:0]       oY_Cont,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [15:0]       oFRAME_CNT
);

  state_t            state;
  logic [1:0]        mode;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  logic [15:0]       split_x;
  logic [15:0]       split_y;
  logic              eol;
  logic              eob;
  logic              eof;
  logic [15:0]       x_inc;
  logic [15:0]       y_inc;

  function automatic logic [DATA_W-1:0] pix(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [15:0]       sx,
    input logic [15:0]       sy,
    input logic [15:0]       px,
    input logic [15:0]       py
  );
    unique case (m)
      MODE_UNIFORM: pix = a;
      MODE_VEDGE:   pix = (px < sx) ? a : b;
      MODE_HEDGE:   pix = (py < sy) ? a : b;
      MODE_RAMP:    pix = DATA_W'(px) + DATA_W'(py);
    endcase
  endfunction

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK)
  ) u_cnt (
    .clk      (iCLK),
    .rst_n    (iRST),
    .clr      (state == IDLE && iSTART),
    .x_step   (state == ACTIVE && !eol),
    .row_step (state == HBLANK && eob && !eof),
    .blk_en   (state == HBLANK),
    .x        (oX_Cont),
    .y        (oY_Cont),
    .eol      (eol),
    .eob      (eob),
    .eof      (eof)
  );

  assign x_inc = oX_Cont + 16'd1;
  assign y_inc = oY_Cont + 16'd1;

  // Outputs are computed for the coordinates the counter moves to
  // on this same edge, so data and position stay aligned.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state      <= IDLE;
      mode       <= '0;
      val_a      <= '0;
      val_b      <= '0;
      split_x    <= '0;
      split_y    <= '0;
      oDATA      <= '0;
      oDVAL      <= 1'b0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oFRAME_CNT <= '0;
    end else begin
      oDONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iSTART) begin
            mode    <= iMODE;
            val_a   <= iVAL_A;
            val_b   <= iVAL_B;
            split_x <= iSPLIT_X;
            split_y <= iSPLIT_Y;
            state   <= ACTIVE;
            oDVAL   <= 1'b1;
            oBUSY   <= 1'b1;
            oDATA   <= pix(iMODE, iVAL_A, iVAL_B,
                           iSPLIT_X, iSPLIT_Y, 16'd0, 16'd0);
          end
        end
        ACTIVE: begin
          if (eol) begin
            state <= HBLANK;
            oDVAL <= 1'b0;
            oDATA <= '0;
          end else begin
            oDATA <= pix(mode, val_a, val_b,
                         split_x, split_y, x_inc, oY_Cont);
          end
        end
        HBLANK: begin
          if (eob) begin
            if (eof) begin
              state      <= DONE;
              oDONE      <= 1'b1;
              oFRAME_CNT <= oFRAME_CNT + 16'd1;
            end else begin
              state <= ACTIVE;
              oDVAL <= 1'b1;
              oDATA <= pix(mode, val_a, val_b,
                           split_x, split_y, 16'd0, y_inc);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raster_pattern_source.sv
// tb_raster_pattern_source: directed bench for raster_pattern_source
// with an 8x3 frame and 2-cycle horizontal blanking.
module tb_raster_pattern_source;

  localparam int HA = 8;
  localparam int VA = 3;
  localparam int HB = 2;
  localparam int DW = 12;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [DW-1:0] va;
  logic [DW-1:0] vb;
  logic [15:0]   sx;
  logic [15:0]   sy;
  logic [DW-1:0] odata;
  logic          odval;
  logic [15:0]   ox;
  logic [15:0]   oy;
  logic          obusy;
  logic          odone;
  logic [15:0]   ofcnt;

  int total = 0;
  int bad = 0;
  int nval;
  int done_at;
  int mism;
  int exp_cnt;
  int seen;
  bit hit;

  raster_pattern_source #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .DATA_W   (DW)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iSTART     (start),
    .iMODE      (mode),
    .iVAL_A     (va),
    .iVAL_B     (vb),
    .iSPLIT_X   (sx),
    .iSPLIT_Y   (sy),
    .oDATA      (odata),
    .oDVAL      (odval),
    .oX_Cont    (ox),
    .oY_Cont    (oy),
    .oBUSY      (obusy),
    .oDONE      (odone),
    .oFRAME_CNT (ofcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int m, input int a, input int b,
                               input int px, input int py,
                               input int x, input int y);
    case (m)
      0: return a;
      1: return (x < px) ? a : b;
      2: return (y < py) ? a : b;
      default: return (x + y) & 12'hFFF;
    endcase
  endfunction

  task automatic pulse_start(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Samples each cycle of a frame against the expected raster;
  // sample 1 is the cycle after start acceptance, DONE expected at 31.
  task automatic capture(input int m, input int a, input int b,
                         input int px, input int py,
                         input bit chg, input bit drop,
                         output int nv, output int dn, output int ms);
    logic          ev;
    logic [DW-1:0] ed;
    logic [15:0]   ex;
    logic [15:0]   ey;
    int p;
    nv = 0;
    dn = 0;
    ms = 0;
    for (int k = 1; k <= 40 && dn == 0; k++) begin
      @(negedge clk);
      if (k == 1 && drop) start = 1'b0;
      if (chg && k == 5) begin
        mode = 2'd3;
        va = 12'd7;
        vb = 12'd9;
        sx = 16'd1;
        sy = 16'd1;
      end
      if (odval) nv++;
      if (odone) dn = k;
      p = k - 1;
      if (k <= VA * (HA + HB)) begin
        ev = (p % (HA + HB)) < HA;
        ed = ev ? DW'(model(m, a, b, px, py, p % (HA + HB), p / (HA + HB))) : '0;
        ex = ev ? 16'(p % (HA + HB)) : 16'(HA - 1);
        ey = 16'(p / (HA + HB));
        if (odval !== ev || odata !== ed || ox !== ex || oy !== ey ||
            obusy !== 1'b1 || odone !== 1'b0)
          ms++;
      end else if (obusy !== 1'b1 || odval !== 1'b0) begin
        ms++;
      end
    end
  endtask

  task automatic frame(input string tag, input int m, input int a,
                       input int b, input int px, input int py,
                       input bit chg);
    mode = 2'(m);
    va = DW'(a);
    vb = DW'(b);
    sx = 16'(px);
    sy = 16'(py);
    pulse_start(1'b0);
    capture(m, a, b, px, py, chg, 1'b0, nval, done_at, mism);
    exp_cnt++;
    chk({tag, "_mism"}, mism, 0);
    chk({tag, "_nval"}, nval, 24);
    chk({tag, "_done_at"}, done_at, 31);
    chk({tag, "_fcnt"}, int'(ofcnt), exp_cnt);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    mode = '0;
    va = '0;
    vb = '0;
    sx = '0;
    sy = '0;
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_dval", int'(odval), 0);
    chk("rst_data", int'(odata), 0);
    chk("rst_busy", int'(obusy), 0);
    chk("rst_done", int'(odone), 0);
    chk("rst_fcnt", int'(ofcnt), 0);
    chk("rst_x", int'(ox), 0);
    chk("rst_y", int'(oy), 0);

    frame("uniform", 0, 200, 0, 0, 0, 1'b0);
    frame("vedge4", 1, 0, 255, 4, 0, 1'b0);
    frame("vedge0", 1, 0, 255, 0, 0, 1'b0);
    frame("vedge8", 1, 100, 50, 8, 0, 1'b0);
    frame("hedge2", 2, 255, 0, 0, 2, 1'b0);
    frame("hedge0", 2, 255, 0, 0, 0, 1'b0);
    frame("ramp", 3, 0, 0, 0, 0, 1'b0);
    frame("cfgchg", 1, 33, 44, 3, 0, 1'b1);

    // start held high across a frame and its DONE cycle
    mode = 2'd0;
    va = 12'd77;
    pulse_start(1'b1);
    capture(0, 77, 0, 0, 0, 1'b0, 1'b0, nval, done_at, mism);
    exp_cnt++;
    chk("hold1_mism", mism, 0);
    chk("hold1_done_at", done_at, 31);
    @(negedge clk);
    chk("hold_gap_dval", int'(odval), 0);
    chk("hold_gap_busy", int'(obusy), 0);
    capture(0, 77, 0, 0, 0, 1'b0, 1'b1, nval, done_at, mism);
    exp_cnt++;
    chk("hold2_mism", mism, 0);
    chk("hold2_nval", nval, 24);
    chk("hold2_done_at", done_at, 31);
    chk("hold2_fcnt", int'(ofcnt), exp_cnt);
    repeat (2) @(negedge clk);
    chk("post_idle_dval", int'(odval), 0);
    chk("post_idle_busy", int'(obusy), 0);

    // reset mid-frame at row 1, column 3
    va = 12'd55;
    pulse_start(1'b0);
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (odval && ox == 16'd3 && oy == 16'd1) hit = 1'b1;
    end
    chk("abort_point", int'(hit), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_dval", int'(odval), 0);
    chk("abort_busy", int'(obusy), 0);
    chk("abort_done", int'(odone), 0);
    chk("abort_fcnt", int'(ofcnt), 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (odone || odval) seen++;
    end
    chk("abort_quiet", seen, 0);
    exp_cnt = 0;
    frame("after_abort", 0, 123, 0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
